mem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one single-ported synchronous RAM between the microcontroller core (port 0) and a program loader/debug master (port 1). It registers the granted request onto the memory bus and waits out the RAM's one-cycle read latency. It then returns read data to the winner with a one-cycle acknowledge. It sits between the microcontroller's rw/addr/dout/din bus and the shared instruction/data RAM.

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of the two requester ports and the shared RAM bus
//               handled by mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int N = 16,
    parameter int A = 16
);
    // Requester port 0 (core) and port 1 (loader/debug)
    logic         req0;
    logic         req1;
    logic         we0;
    logic         we1;
    logic [A-1:0] addr0;
    logic [A-1:0] addr1;
    logic [N-1:0] wdata0;
    logic [N-1:0] wdata1;
    logic         ack0;
    logic         ack1;
    logic         gnt0;
    logic         gnt1;
    logic [N-1:0] rdata0;
    logic [N-1:0] rdata1;

    // Shared single-ported RAM
    logic         mem_cs;
    logic         mem_we;
    logic [A-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;

    logic         busy;

    // Arbiter side
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, gnt0, gnt1, rdata0, rdata1,
               mem_cs, mem_we, mem_addr, mem_wdata, busy
    );

    // Requesters plus RAM side
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, gnt0, gnt1, rdata0, rdata1,
               mem_cs, mem_we, mem_addr, mem_wdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port round-robin arbiter sharing one synchronous RAM with
//               one-cycle read latency. Every transaction runs ACC, WAIT,
//               RESP; all outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int N = 16,
    parameter int A = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,      // asynchronous, active-low
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t       r_state,     w_state;
    logic         r_last,      w_last;      // most recently granted port
    logic         r_win,       w_win;       // port owning the current transaction
    logic         r_win_we,    w_win_we;    // current transaction is a write
    logic         r_ack0,      w_ack0;
    logic         r_ack1,      w_ack1;
    logic         r_gnt0,      w_gnt0;
    logic         r_gnt1,      w_gnt1;
    logic [N-1:0] r_rdata0,    w_rdata0;
    logic [N-1:0] r_rdata1,    w_rdata1;
    logic         r_mem_cs,    w_mem_cs;
    logic         r_mem_we,    w_mem_we;
    logic [A-1:0] r_mem_addr,  w_mem_addr;
    logic [N-1:0] r_mem_wdata, w_mem_wdata;
    logic         r_busy,      w_busy;

    logic         w_req0_eff;
    logic         w_req1_eff;
    logic         w_grant;
    logic         w_pick;

    // Arbitration: only IDLE and RESP may grant; in RESP the port just acked is masked
    always_comb begin
        w_req0_eff = 1'b0;
        w_req1_eff = 1'b0;
        if (r_state == S_IDLE) begin
            w_req0_eff = bus.req0;
            w_req1_eff = bus.req1;
        end else if (r_state == S_RESP) begin
            w_req0_eff = bus.req0 & r_win;
            w_req1_eff = bus.req1 & ~r_win;
        end
        w_grant = w_req0_eff | w_req1_eff;
        w_pick  = (w_req0_eff & w_req1_eff) ? ~r_last : w_req1_eff;
    end

    // State and registered-output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_win       <= 1'b0;
            r_win_we    <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_mem_cs    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_last      <= w_last;
            r_win       <= w_win;
            r_win_we    <= w_win_we;
            r_ack0      <= w_ack0;
            r_ack1      <= w_ack1;
            r_gnt0      <= w_gnt0;
            r_gnt1      <= w_gnt1;
            r_rdata0    <= w_rdata0;
            r_rdata1    <= w_rdata1;
            r_mem_cs    <= w_mem_cs;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_busy      <= w_busy;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        w_state     = r_state;
        w_last      = r_last;
        w_win       = r_win;
        w_win_we    = r_win_we;
        w_ack0      = 1'b0;
        w_ack1      = 1'b0;
        w_gnt0      = r_gnt0;
        w_gnt1      = r_gnt1;
        w_rdata0    = r_rdata0;
        w_rdata1    = r_rdata1;
        w_mem_cs    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;

        case (r_state)
            S_IDLE, S_RESP: begin
                if (w_grant) begin
                    // Load the winner's request onto the RAM bus
                    w_state     = S_ACC;
                    w_last      = w_pick;
                    w_win       = w_pick;
                    w_win_we    = w_pick ? bus.we1 : bus.we0;
                    w_gnt0      = ~w_pick;
                    w_gnt1      = w_pick;
                    w_mem_cs    = 1'b1;
                    w_mem_we    = w_pick ? bus.we1 : bus.we0;
                    w_mem_addr  = w_pick ? bus.addr1 : bus.addr0;
                    w_mem_wdata = w_pick ? bus.wdata1 : bus.wdata0;
                end else begin
                    w_state = S_IDLE;
                    w_gnt0  = 1'b0;
                    w_gnt1  = 1'b0;
                end
            end
            S_ACC: begin
                // RAM samples the bus at this edge; select drops by default
                w_state = S_WAIT;
            end
            S_WAIT: begin
                // Read data is valid now; writes leave rdata untouched
                if (!r_win_we) begin
                    if (r_win) w_rdata1 = bus.mem_rdata;
                    else       w_rdata0 = bus.mem_rdata;
                end
                w_ack0  = ~r_win;
                w_ack1  = r_win;
                w_state = S_RESP;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;
    assign bus.mem_cs    = r_mem_cs;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed bench for mem_arbiter with a RAM model and an
//               in-order scoreboard of expected acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.N(16), .A(16)) bus ();

    mem_arbiter #(.N(16), .A(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Synchronous RAM, read data valid the cycle after a read select
    logic [15:0] ram [0:65535];
    logic        pl_en   = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [15:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        if (bus.mem_cs) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    typedef struct {
        int          port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model [0:65535];
    int          checks   = 0;
    int          failures = 0;
    int          gap_mode  = 0;
    int          gap_epoch = 0;

    // Monitor state
    int          mon_cyc   = 0;
    int          mon_last  = 0;
    int          mon_epoch = 0;
    int          mon_w0    = 0;
    int          mon_w1    = 0;
    int          mon_p     = 0;
    bit          mon_have_prev = 1'b0;
    bit          mon_prev_ack  = 1'b0;
    logic [15:0] hold0 = '0;
    logic [15:0] hold1 = '0;
    exp_t        mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        model[a] = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic expect_txn(input int p, input logic we, input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        if (we) model[a] = d;
        e.port = p;
        e.we   = we;
        e.addr = a;
        e.data = we ? 16'h0000 : model[a];
        sb.push_back(e);
    endtask

    task automatic drive_port(input int p, input logic r, input logic we,
                              input logic [15:0] a, input logic [15:0] d);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    // Issue n transactions back to back on one port, holding req until each ack
    task automatic run_port(input int p, input int n, input logic we, input logic [15:0] base,
                            input logic [15:0] dbase, input int step);
        bit got;
        int cnt;
        for (int k = 0; k < n; k++) begin
            drive_port(p, 1'b1, we, base + 16'(k * step), dbase + 16'(k));
            got = 1'b0;
            cnt = 0;
            while (!got && cnt < 40) begin
                @(negedge clk);
                cnt++;
                got = (p == 1) ? bus.ack1 : bus.ack0;
            end
            check("txn_done", 32'(got), 32'd1);
        end
        drive_port(p, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 32'({bus.ack0, bus.ack1, bus.gnt0, bus.gnt1,
                                   bus.mem_cs, bus.mem_we, bus.busy}), 32'd0);
        check({tag, "_bus"},  {bus.mem_addr, bus.mem_wdata}, 32'd0);
        check({tag, "_rd"},   {bus.rdata0, bus.rdata1}, 32'd0);
    endtask

    initial begin
        // Scoreboard / protocol monitor, sampled on the falling edge
        fork
            forever begin
                @(negedge clk);
                mon_cyc++;
                if (gap_epoch != mon_epoch) begin
                    mon_epoch     = gap_epoch;
                    mon_have_prev = 1'b0;
                end
                if (!rst) begin
                    hold0 = '0; hold1 = '0;
                    mon_w0 = 0; mon_w1 = 0;
                    mon_prev_ack = 1'b0;
                end else begin
                    if (bus.ack0 || bus.ack1) begin
                        check("ack_onehot", 32'(bus.ack0 & bus.ack1), 32'd0);
                        check("ack_pulse", 32'(mon_prev_ack), 32'd0);
                        mon_p = bus.ack1 ? 1 : 0;
                        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                        if (sb.size() != 0) begin
                            mon_e = sb.pop_front();
                            check("grant_order", 32'(mon_p), 32'(mon_e.port));
                            check("resp_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
                            if (!mon_e.we) begin
                                if (mon_p == 1) hold1 = mon_e.data;
                                else            hold0 = mon_e.data;
                            end
                        end
                        if (gap_mode != 0 && mon_have_prev)
                            check("ack_gap", 32'(mon_cyc - mon_last), 32'(gap_mode));
                        mon_last      = mon_cyc;
                        mon_have_prev = 1'b1;
                    end
                    check("rdata0", 32'(bus.rdata0), 32'(hold0));
                    check("rdata1", 32'(bus.rdata1), 32'(hold1));
                    if (bus.mem_cs && bus.gnt0) begin
                        check("starve0", 32'(mon_w0 <= 3), 32'd1);
                        mon_w0 = 0;
                    end else if (bus.req0 && !bus.gnt0 && bus.busy) mon_w0++;
                    if (bus.mem_cs && bus.gnt1) begin
                        check("starve1", 32'(mon_w1 <= 3), 32'd1);
                        mon_w1 = 0;
                    end else if (bus.req1 && !bus.gnt1 && bus.busy) mon_w1++;
                    mon_prev_ack = bus.ack0 | bus.ack1;
                end
            end
        join_none

        // Reset and RAM preload
        drive_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive_port(1, 1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b0;
        preload(16'h0010, 16'hBEEF);
        preload(16'h0020, 16'h5555);
        preload(16'h0021, 16'h6666);
        for (int i = 0; i < 6; i++) preload(16'h0040 + 16'(i), 16'hA000 + 16'(i));
        for (int i = 0; i < 4; i++) preload(16'h0050 + 16'(i), 16'hC000 + 16'(i));
        @(negedge clk);
        check_reset_outputs("in_reset");
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_reset_outputs("idle");
        end

        // Single read, port 0, cycle by cycle
        expect_txn(0, 1'b0, 16'h0010, 16'h0);
        drive_port(0, 1'b1, 1'b0, 16'h0010, 16'h0);
        @(negedge clk);
        check("rd_acc_cs", 32'({bus.mem_cs, bus.mem_we, bus.gnt0, bus.gnt1, bus.busy}), 32'b10101);
        check("rd_acc_addr", 32'(bus.mem_addr), 32'h0010);
        @(negedge clk);
        check("rd_wait", 32'({bus.mem_cs, bus.ack0}), 32'd0);
        @(negedge clk);
        check("rd_ack", 32'(bus.ack0), 32'd1);
        check("rd_data", 32'(bus.rdata0), 32'hBEEF);
        drive_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        check("rd_done", 32'({bus.ack0, bus.gnt0, bus.busy}), 32'd0);

        // Port 1 write then read back
        expect_txn(1, 1'b1, 16'h0003, 16'h1234);
        expect_txn(1, 1'b0, 16'h0003, 16'h0);
        run_port(1, 1, 1'b1, 16'h0003, 16'h1234, 0);
        @(negedge clk);
        run_port(1, 1, 1'b0, 16'h0003, 16'h0, 0);
        check("wr_rd_data", 32'(bus.rdata1), 32'h1234);
        @(negedge clk);

        // Tie: both ports continuously, last grant was port 1
        for (int i = 0; i < 6; i++) expect_txn(i % 2, 1'b0, 16'h0040 + 16'(i), 16'h0);
        gap_mode = 3;
        gap_epoch++;
        fork
            run_port(0, 3, 1'b0, 16'h0040, 16'h0, 2);
            run_port(1, 3, 1'b0, 16'h0041, 16'h0, 2);
        join
        gap_mode = 0;
        @(negedge clk);
        @(negedge clk);

        // Port 0 streaming alone
        for (int i = 0; i < 4; i++) expect_txn(0, 1'b0, 16'h0050 + 16'(i), 16'h0);
        gap_mode = 4;
        gap_epoch++;
        run_port(0, 4, 1'b0, 16'h0050, 16'h0, 1);
        gap_mode = 0;
        @(negedge clk);
        @(negedge clk);

        // Reset during WAIT of a port-0 read
        drive_port(0, 1'b1, 1'b0, 16'h0020, 16'h0);
        @(negedge clk);
        @(negedge clk);
        check("mid_wait", 32'({bus.busy, bus.gnt0, bus.mem_cs, bus.ack0}), 32'b1100);
        rst = 1'b0;
        drive_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_noack", 32'({bus.ack0, bus.busy}), 32'd0);

        // Tie after reset: port 0 must win first
        expect_txn(0, 1'b0, 16'h0020, 16'h0);
        expect_txn(1, 1'b0, 16'h0021, 16'h0);
        fork
            run_port(0, 1, 1'b0, 16'h0020, 16'h0, 0);
            run_port(1, 1, 1'b0, 16'h0021, 16'h0, 0);
        join
        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
